// File: rtl/blob_centroid_tracker.sv
`default_nettype none
// ============================================================================
// Module   : blob_centroid_tracker
// Purpose  : Accumulates the coordinates of masked pixels over a frame and,
//            at end of frame, divides the coordinate sums by the pixel count
//            with two bit-serial restoring dividers to report the blob
//            centroid and area.
// Options  : define CENTROID_SMOOTH_EN to average each new centroid with the
//            previously reported one.
// Revision : 1.0 - initial release
// ============================================================================
module blob_centroid_tracker #(
  parameter  int HRES   = 320,
  parameter  int VRES   = 180,
  localparam int HWIDTH = $clog2(HRES),
  localparam int VWIDTH = $clog2(VRES),
  localparam int AWIDTH = $clog2(HRES * VRES)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [HWIDTH-1:0] hcount_in,
  input  logic [VWIDTH-1:0] vcount_in,
  input  logic              mask_in,
  input  logic              valid_in,
  input  logic              frame_done_in,
  output logic [HWIDTH-1:0] x_out,
  output logic [VWIDTH-1:0] y_out,
  output logic [AWIDTH-1:0] area_out,
  output logic              valid_out,
  output logic              busy_out,
  output logic              drop_out
);

  localparam int SXW = HWIDTH + AWIDTH;   // sum_x width
  localparam int SYW = VWIDTH + AWIDTH;   // sum_y width
  localparam int NB  = SXW;               // dividend width / divide cycles
  localparam int STW = $clog2(NB);        // divide step counter width

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_EMIT   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Running accumulators for the frame currently being received
  logic [SXW-1:0]    r_sum_x;
  logic [SYW-1:0]    r_sum_y;
  logic [AWIDTH-1:0] r_count;

  // Divider registers: the dividend shifts out at the top while quotient
  // bits shift in at the bottom, so after NB steps it holds the quotient.
  logic [NB-1:0]     r_quo_x;
  logic [NB-1:0]     r_quo_y;
  logic [AWIDTH-1:0] r_rem_x;
  logic [AWIDTH-1:0] r_rem_y;
  logic [AWIDTH-1:0] r_den;
  logic [STW-1:0]    r_step;

  // Output registers
  logic [HWIDTH-1:0] r_x;
  logic [VWIDTH-1:0] r_y;
  logic [AWIDTH-1:0] r_area;
  logic              r_valid;
  logic              r_drop;
`ifdef CENTROID_SMOOTH_EN
  logic              r_have_prev;
`endif

  // Pixel qualification and next accumulator values (pixel included)
  logic              w_in_range;
  logic              w_sat;
  logic              w_pix;
  logic [SXW-1:0]    w_sx_nxt;
  logic [SYW-1:0]    w_sy_nxt;
  logic [AWIDTH-1:0] w_cnt_nxt;
  logic              w_close;
  logic              w_drop_evt;

  assign w_in_range = (32'(hcount_in) < HRES) && (32'(vcount_in) < VRES);
  // A saturated count freezes the whole frame's statistics
  assign w_sat      = &r_count;
  assign w_pix      = valid_in & mask_in & w_in_range & ~w_sat;
  assign w_sx_nxt   = w_pix ? (r_sum_x + SXW'(hcount_in)) : r_sum_x;
  assign w_sy_nxt   = w_pix ? (r_sum_y + SYW'(vcount_in)) : r_sum_y;
  assign w_cnt_nxt  = w_pix ? (r_count + AWIDTH'(1)) : r_count;
  assign w_close    = frame_done_in & (r_state == ST_ACCUM);
  assign w_drop_evt = frame_done_in & (r_state != ST_ACCUM);

  // One restoring-division step for each axis
  logic [AWIDTH:0]   w_trial_x, w_trial_y;
  logic [AWIDTH:0]   w_diff_x, w_diff_y;
  logic              w_ge_x, w_ge_y;
  logic [AWIDTH-1:0] w_rem_x_nxt, w_rem_y_nxt;
  logic [NB-1:0]     w_quo_x_nxt, w_quo_y_nxt;
  logic              w_last_step;

  assign w_trial_x   = {r_rem_x, r_quo_x[NB-1]};
  assign w_trial_y   = {r_rem_y, r_quo_y[NB-1]};
  assign w_diff_x    = w_trial_x - {1'b0, r_den};
  assign w_diff_y    = w_trial_y - {1'b0, r_den};
  assign w_ge_x      = (w_trial_x >= {1'b0, r_den});
  assign w_ge_y      = (w_trial_y >= {1'b0, r_den});
  // The remainder stays below the divisor, so AWIDTH bits always suffice
  assign w_rem_x_nxt = w_ge_x ? w_diff_x[AWIDTH-1:0] : w_trial_x[AWIDTH-1:0];
  assign w_rem_y_nxt = w_ge_y ? w_diff_y[AWIDTH-1:0] : w_trial_y[AWIDTH-1:0];
  assign w_quo_x_nxt = {r_quo_x[NB-2:0], w_ge_x};
  assign w_quo_y_nxt = {r_quo_y[NB-2:0], w_ge_y};
  assign w_last_step = (r_state == ST_DIVIDE) && (r_step == STW'(NB - 1));

  // Final quotients and their average with the currently reported centroid
  logic [HWIDTH-1:0] w_xq;
  logic [VWIDTH-1:0] w_yq;
  logic [HWIDTH:0]   w_x_sum;
  logic [VWIDTH:0]   w_y_sum;

  assign w_xq    = w_quo_x_nxt[HWIDTH-1:0];
  assign w_yq    = w_quo_y_nxt[VWIDTH-1:0];
  assign w_x_sum = {1'b0, r_x} + {1'b0, w_xq};
  assign w_y_sum = {1'b0, r_y} + {1'b0, w_yq};

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= ST_ACCUM;
    else        r_state <= w_state_next;
  end

  // Next-state logic: empty frames skip the divider entirely
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ACCUM:  if (frame_done_in)
                   w_state_next = (w_cnt_nxt != '0) ? ST_DIVIDE : ST_EMIT;
      ST_DIVIDE: if (w_last_step) w_state_next = ST_EMIT;
      ST_EMIT:   w_state_next = ST_ACCUM;
      default:   w_state_next = ST_ACCUM;
    endcase
  end

  // Accumulators: any frame_done clears them; the next frame starts at once
  always_ff @(posedge clk_in) begin
    if (rst_in || frame_done_in) begin
      r_sum_x <= '0;
      r_sum_y <= '0;
      r_count <= '0;
    end else begin
      r_sum_x <= w_sx_nxt;
      r_sum_y <= w_sy_nxt;
      r_count <= w_cnt_nxt;
    end
  end

  // Divider: load the closing frame's totals, then shift one bit per cycle
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_quo_x <= '0;
      r_quo_y <= '0;
      r_rem_x <= '0;
      r_rem_y <= '0;
      r_den   <= '0;
      r_step  <= '0;
    end else if (w_close) begin
      r_quo_x <= w_sx_nxt;
      r_quo_y <= NB'(w_sy_nxt);
      r_rem_x <= '0;
      r_rem_y <= '0;
      r_den   <= w_cnt_nxt;
      r_step  <= '0;
    end else if (r_state == ST_DIVIDE) begin
      r_quo_x <= w_quo_x_nxt;
      r_quo_y <= w_quo_y_nxt;
      r_rem_x <= w_rem_x_nxt;
      r_rem_y <= w_rem_y_nxt;
      r_step  <= r_step + STW'(1);
    end
  end

  // Result registers, updated on the edge that enters EMIT so that
  // valid_out coincides with the EMIT state
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_x         <= '0;
      r_y         <= '0;
      r_area      <= '0;
      r_valid     <= 1'b0;
      r_drop      <= 1'b0;
`ifdef CENTROID_SMOOTH_EN
      r_have_prev <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_drop  <= w_drop_evt;
      if (w_close && (w_cnt_nxt == '0)) begin
        r_area  <= '0;
        r_valid <= 1'b1;
      end else if (w_last_step) begin
        r_area  <= r_den;
        r_valid <= 1'b1;
`ifdef CENTROID_SMOOTH_EN
        r_have_prev <= 1'b1;
        if (r_have_prev) begin
          r_x <= w_x_sum[HWIDTH:1];
          r_y <= w_y_sum[VWIDTH:1];
        end else begin
          r_x <= w_xq;
          r_y <= w_yq;
        end
`else
        r_x <= w_xq;
        r_y <= w_yq;
`endif
      end
    end
  end

`ifndef CENTROID_SMOOTH_EN
  // The averaging sums only feed the smoothing path
  logic w_unused_sum;
  assign w_unused_sum = ^{w_x_sum, w_y_sum};
`endif

  assign x_out     = r_x;
  assign y_out     = r_y;
  assign area_out  = r_area;
  assign valid_out = r_valid;
  assign drop_out  = r_drop;
  assign busy_out  = (r_state == ST_DIVIDE);

endmodule
`default_nettype wire
